// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared widths, mirror addresses and responder FSM encoding
package cpu_mem_pkg;
  localparam int CM_AW = 5;
  localparam int CM_DW = 8;
  localparam int CM_MIR0 = 3;
  localparam int CM_MIR1 = 4;
  localparam int CM_MIR2 = 7;
  typedef enum logic [2:0] {ST_IDLE, ST_LATCH, ST_WAIT, ST_RESP, ST_HOLD} state_t;
endpackage

// File: rtl/mem_wait_ctr.sv
// mem_wait_ctr: 3-bit loadable down-counter pacing responder wait states
module mem_wait_ctr (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [2:0] din,
  output logic       zero
);
  logic [2:0] cnt;
  // load wins over decrement; decrement stops at zero
  always_ff @(posedge clock)
    if (reset) cnt <= '0;
    else if (load) cnt <= din;
    else if (dec && cnt != '0) cnt <= cnt - 3'd1;
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: req/ack word store with wait states and output mirrors; MEMRESP_WRPROT_EN adds write protection
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int AW = CM_AW,
  parameter int DW = CM_DW,
  parameter int WAIT = 1,
  parameter int MIR0 = CM_MIR0,
  parameter int MIR1 = CM_MIR1,
  parameter int MIR2 = CM_MIR2,
  parameter int PROT_BASE = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] m3,
  output logic [DW-1:0] m4,
  output logic [DW-1:0] m5
);
  state_t state, nxt;
  logic [AW-1:0] addr_q, wa;
  logic [DW-1:0] wdata_q, wd;
  logic we_q, zero, go, prot, wr, ld, latch, pace;
  logic [DW-1:0] mem [2**AW];
  if (WAIT < 0 || WAIT > 7) begin : g_bad_wait
    $error("mem_responder: WAIT must be 0..7");
  end
  if (PROT_BASE < 0 || PROT_BASE > 2**AW) begin : g_bad_prot
    $error("mem_responder: PROT_BASE out of range");
  end
  assign ld = state == ST_IDLE && ld_en;
  assign latch = state == ST_IDLE && !ld_en && req;
  assign pace = state == ST_LATCH || state == ST_WAIT;
  assign go = pace && zero;
  assign busy = state != ST_IDLE;
`ifdef MEMRESP_WRPROT_EN
  assign prot = int'(addr_q) >= PROT_BASE;
`else
  assign prot = 1'b0;
`endif
  assign wr = !reset && (ld || (go && we_q && !prot));
  assign wa = ld ? ld_addr : addr_q;
  assign wd = ld ? ld_data : wdata_q;
  mem_wait_ctr u_ctr (
    .clock(clock),
    .reset(reset),
    .load (latch),
    .dec  (pace && !zero),
    .din  (3'(WAIT)),
    .zero (zero)
  );
  // next state: a pending load keeps the FSM idle for one edge
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:           nxt = latch ? ST_LATCH : ST_IDLE;
      ST_LATCH, ST_WAIT: nxt = zero ? ST_RESP : ST_WAIT;
      ST_RESP:           nxt = ST_HOLD;
      ST_HOLD:           nxt = req ? ST_HOLD : ST_IDLE;
      default:           nxt = ST_IDLE;
    endcase
  end
  // request fields are captured once, on acceptance
  always_ff @(posedge clock)
    if (latch) begin
      addr_q <= addr;
      we_q <= we;
      wdata_q <= wdata;
    end
  // storage is deliberately left uncleared by reset
  always_ff @(posedge clock)
    if (wr) mem[wa] <= wd;
  // FSM state, response pulses, read data and mirrors
  always_ff @(posedge clock)
    if (reset) begin
      state <= ST_IDLE;
      ack <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
      m3 <= '0;
      m4 <= '0;
      m5 <= '0;
    end else begin
      state <= nxt;
      ack <= go;
      err <= go && we_q && prot;
      if (go && !we_q) rdata <= mem[addr_q];
      if (wr && wa == AW'(MIR0)) m3 <= wd;
      if (wr && wa == AW'(MIR1)) m4 <= wd;
      if (wr && wa == AW'(MIR2)) m5 <= wd;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table, corner-case and random checks of two responders (WAIT=0 and WAIT=3)
module tb_mem_responder;
`ifdef MEMRESP_WRPROT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req[2], we[2], ld_en[2], ack[2], busy[2], err[2];
  logic [4:0] addr[2], ld_addr[2];
  logic [7:0] wdata[2], ld_data[2], rdata[2], m3[2], m4[2], m5[2];
  logic [7:0] mem_m[2][32];
  logic [7:0] mir_m[2][3];
  logic [7:0] rd_m[2];
  int n_chk = 0;
  int n_fail = 0;
  int wt[2] = '{0, 3};
  typedef struct {
    bit ld;
    bit w;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[11];

  always #5 clock = ~clock;

  mem_responder #(.WAIT(0)) u0 (
    .clock(clock), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]), .err(err[0]), .ld_en(ld_en[0]),
    .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .m3(m3[0]), .m4(m4[0]), .m5(m5[0])
  );
  mem_responder #(.WAIT(3)) u1 (
    .clock(clock), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]), .err(err[1]), .ld_en(ld_en[1]),
    .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .m3(m3[1]), .m4(m4[1]), .m5(m5[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit prot_hit(input logic [4:0] a);
    return PROT_ON && a >= 5'd9;
  endfunction

  task automatic upd(input int d, input logic [4:0] a, input logic [7:0] v);
    mem_m[d][a] = v;
    if (a == 5'd3) mir_m[d][0] = v;
    if (a == 5'd4) mir_m[d][1] = v;
    if (a == 5'd7) mir_m[d][2] = v;
  endtask

  task automatic chk_mir(input int d);
    chk("m3", m3[d], mir_m[d][0]);
    chk("m4", m4[d], mir_m[d][1]);
    chk("m5", m5[d], mir_m[d][2]);
  endtask

  task automatic chk_reset(input int d);
    chk("reset ack", ack[d], 0);
    chk("reset err", err[d], 0);
    chk("reset busy", busy[d], 0);
    chk("reset rdata", rdata[d], 0);
    chk("reset m3", m3[d], 0);
    chk("reset m4", m4[d], 0);
    chk("reset m5", m5[d], 0);
  endtask

  task automatic clr_model();
    for (int d = 0; d < 2; d++) begin
      rd_m[d] = 8'h00;
      for (int k = 0; k < 3; k++) mir_m[d][k] = 8'h00;
    end
  endtask

  task automatic ld(input int d, input logic [4:0] a, input logic [7:0] v);
    @(negedge clock);
    ld_en[d] = 1'b1;
    ld_addr[d] = a;
    ld_data[d] = v;
    @(negedge clock);
    ld_en[d] = 1'b0;
    upd(d, a, v);
    chk_mir(d);
  endtask

  task automatic txn(input int d, input bit w, input logic [4:0] a, input logic [7:0] wd,
                     input bit early, input int hold);
    int n;
    bit p;
    @(negedge clock);
    req[d] = 1'b1;
    we[d] = w;
    addr[d] = a;
    wdata[d] = wd;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        we[d] = ~w;
        addr[d] = a + 5'd1;
        wdata[d] = ~wd;
        ld_en[d] = 1'b1;
        ld_addr[d] = a;
        ld_data[d] = ~wd;
        if (early) req[d] = 1'b0;
      end
    end while (!ack[d] && n < 20);
    ld_en[d] = 1'b0;
    p = w && prot_hit(a);
    if (w && !p) upd(d, a, wd);
    else if (!w) rd_m[d] = mem_m[d][a];
    chk("ack latency", n, wt[d] + 2);
    chk("ack", ack[d], 1);
    chk("rdata", rdata[d], rd_m[d]);
    chk("err", err[d], p);
    chk_mir(d);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold ack", ack[d], 0);
      chk("hold busy", busy[d], 1);
    end
    req[d] = 1'b0;
    @(negedge clock);
    chk("ack pulse", ack[d], 0);
    chk("err pulse", err[d], 0);
    if (hold == 0) @(negedge clock);
    chk("idle busy", busy[d], 0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n, d, hl;
    bit e;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; ld_en[i] = 1'b0;
      addr[i] = '0; ld_addr[i] = '0; wdata[i] = '0; ld_data[i] = '0;
    end
    clr_model();
    tbl = '{
      '{1'b1, 1'b0, 5'd9, 8'hE9, 8'h00},
      '{1'b0, 1'b0, 5'd9, 8'h00, 8'hE9},
      '{1'b0, 1'b1, 5'd5, 8'h3C, 8'h00},
      '{1'b0, 1'b0, 5'd5, 8'h00, 8'h3C},
      '{1'b1, 1'b0, 5'd3, 8'h77, 8'h00},
      '{1'b0, 1'b0, 5'd3, 8'h00, 8'h77},
      '{1'b0, 1'b1, 5'd8, 8'h81, 8'h00},
      '{1'b0, 1'b0, 5'd8, 8'h00, 8'h81},
      '{1'b0, 1'b0, 5'd9, 8'h00, 8'hE9},
      '{1'b0, 1'b1, 5'd4, 8'h5A, 8'h00},
      '{1'b0, 1'b0, 5'd4, 8'h00, 8'h5A}
    };
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) chk_reset(i);
    reset = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 32; a++) ld(i, 5'(a), 8'($urandom));
    foreach (tbl[i]) begin
      if (tbl[i].ld) ld(0, tbl[i].a, tbl[i].d);
      else begin
        txn(0, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, 0);
        if (!tbl[i].w) chk("table rdata", rdata[0], tbl[i].exp);
      end
    end
    txn(1, 1'b1, 5'd7, 8'h05, 1'b0, 0);
    chk("wait3 m5", m5[1], 8'h05);
    txn(1, 1'b0, 5'd7, 8'h00, 1'b0, 0);
    chk("wait3 read", rdata[1], 8'h05);
    txn(0, 1'b0, 5'd12, 8'h00, 1'b0, 5);
    txn(0, 1'b1, 5'd2, 8'h3C, 1'b0, 0);
    txn(0, 1'b0, 5'd2, 8'h00, 1'b0, 0);
    chk("after hold read", rdata[0], 8'h3C);
    @(negedge clock);
    ld_en[0] = 1'b1; ld_addr[0] = 5'd3; ld_data[0] = 8'h22;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 5'd3;
    @(negedge clock);
    ld_en[0] = 1'b0;
    upd(0, 5'd3, 8'h22);
    chk("ld+req idle", busy[0], 0);
    chk("ld+req m3", m3[0], 8'h22);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ack[0] && n < 20);
    chk("ld+req latency", n, 2);
    chk("ld+req rdata", rdata[0], 8'h22);
    rd_m[0] = 8'h22;
    req[0] = 1'b0;
    repeat (2) @(negedge clock);
    chk("ld+req done", busy[0], 0);
    ld(1, 5'd4, 8'h4B);
    @(negedge clock);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 5'd4; wdata[1] = 8'hAA;
    repeat (2) @(negedge clock);
    chk("in wait busy", busy[1], 1);
    reset = 1'b1;
    req[1] = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 2; i++) chk_reset(i);
    reset = 1'b0;
    clr_model();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("aborted ack", ack[1], 0);
    end
    txn(1, 1'b0, 5'd4, 8'h00, 1'b0, 0);
    chk("aborted write", rdata[1], 8'h4B);
`ifdef MEMRESP_WRPROT_EN
    ld(0, 5'd20, 8'h5E);
    txn(0, 1'b1, 5'd20, 8'h11, 1'b0, 0);
    txn(0, 1'b0, 5'd20, 8'h00, 1'b0, 0);
    chk("protected kept", rdata[0], 8'h5E);
    txn(0, 1'b1, 5'd8, 8'h66, 1'b0, 0);
    txn(0, 1'b0, 5'd8, 8'h00, 1'b0, 0);
    chk("unprotected write", rdata[0], 8'h66);
`endif
    for (int i = 0; i < 80; i++) begin
      d = i % 2;
      e = $urandom_range(0, 3) == 0;
      hl = e ? 0 : int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clock);
      if ($urandom_range(0, 5) == 0) ld(d, 5'($urandom), 8'($urandom));
      else txn(d, 1'($urandom), 5'($urandom), 8'($urandom), e, hl);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
